dispense_sequencer: RTL and testbench

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

---
 rtl/dispense_sequencer.sv | 108 ++++++++++
 tb/tb_dispense_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_sequencer.sv
// Vend sequencer: runs the product motor, then pays change one pulse per coin,
// then issues a one-cycle done strobe. All outputs are registered.
module dispense_sequencer #(
  parameter int unsigned MOTOR_CYCLES = 8,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic [2:0] p,
  input  logic [2:0] c,
  output logic       busy,
  output logic       motor_en,
  output logic [2:0] motor_sel,
  output logic       change_pulse,
  output logic [2:0] change_left,
  output logic       done,
  output logic       ovr,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOTOR  = 3'd1,
    CHG_HI = 3'd2,
    CHG_LO = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Counters hold "cycles remaining minus one", so load the width minus one.
  localparam logic [7:0] MOTOR_LD = 8'(MOTOR_CYCLES - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] left_n;

  assign fsm_state = state;

  always_comb begin
    state_n = state;
    left_n  = change_left;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (d) begin
          left_n = c;
          if (p != 3'd0)      state_n = MOTOR;
          else if (c != 3'd0) state_n = CHG_HI;
          else                state_n = DONE;
        end
      end
      MOTOR: begin
        if (cnt == 8'd0) state_n = (change_left != 3'd0) ? CHG_HI : DONE;
      end
      CHG_HI: begin
        if (cnt == 8'd0) begin
          if (change_left != 3'd0) left_n = change_left - 3'd1;
          state_n = CHG_LO;
        end
      end
      CHG_LO: begin
        if (cnt == 8'd0) state_n = (change_left != 3'd0) ? CHG_HI : DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Every state entry reloads the timer; otherwise it counts down to zero.
    if (state_n != state) begin
      case (state_n)
        MOTOR:   cnt_n = MOTOR_LD;
        CHG_HI:  cnt_n = PULSE_LD;
        CHG_LO:  cnt_n = GAP_LD;
        default: cnt_n = 8'd0;
      endcase
    end else if (cnt != 8'd0) begin
      cnt_n = cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      change_left  <= 3'd0;
      motor_sel    <= 3'd0;
      busy         <= 1'b0;
      motor_en     <= 1'b0;
      change_pulse <= 1'b0;
      done         <= 1'b0;
      ovr          <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      change_left  <= left_n;
      busy         <= (state_n != IDLE);
      motor_en     <= (state_n == MOTOR);
      change_pulse <= (state_n == CHG_HI);
      done         <= (state_n == DONE);
      if (state == IDLE && d) motor_sel <= p;
      if (state != IDLE && d) ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: directed vend table, overrun and reset corners,
// then random vends checked cycle by cycle against a segment-based model.
module tb_dispense_sequencer;

  localparam int MOTOR_CYCLES = 8;
  localparam int PULSE_CYCLES = 2;
  localparam int GAP_CYCLES   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d = 1'b0;
  logic [2:0] p = 3'd0;
  logic [2:0] c = 3'd0;
  logic       busy, motor_en, change_pulse, done, ovr;
  logic [2:0] motor_sel, change_left, fsm_state;

  dispense_sequencer #(
    .MOTOR_CYCLES(MOTOR_CYCLES),
    .PULSE_CYCLES(PULSE_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .p           (p),
    .c           (c),
    .busy        (busy),
    .motor_en    (motor_en),
    .motor_sel   (motor_sel),
    .change_pulse(change_pulse),
    .change_left (change_left),
    .done        (done),
    .ovr         (ovr),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       motor;
    logic [2:0] sel;
    logic       pulse;
    logic [2:0] left;
    logic       done;
    logic       ovr;
  } out_t;

  typedef struct {
    logic [2:0] p;
    logic [2:0] c;
    int         motor;
    int         pulses;
    int         done_at;
  } vec_t;

  out_t       exp_q[$];
  logic       exp_ovr;
  logic [2:0] last_sel;
  logic       cur_busy;
  out_t       last_act;
  int         total = 0;
  int         bad = 0;

  function automatic out_t sample();
    return {busy, motor_en, motor_sel, change_pulse, change_left, done, ovr};
  endfunction

  task automatic check_out(input string name, input out_t a, input out_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t: got busy=%b mot=%b sel=%0d pls=%b left=%0d done=%b ovr=%b, expected busy=%b mot=%b sel=%0d pls=%b left=%0d done=%b ovr=%b",
               name, $time, a.busy, a.motor, a.sel, a.pulse, a.left, a.done, a.ovr,
               e.busy, e.motor, e.sel, e.pulse, e.left, e.done, e.ovr);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  // Model: a vend is a list of segments (motor, then pulse/gap per coin, then done).
  task automatic push_vend(input logic [2:0] pv, input logic [2:0] cv);
    out_t r;
    last_sel = pv;
    r = '0;
    r.busy = 1'b1;
    r.sel  = pv;
    if (pv != 0)
      for (int i = 0; i < MOTOR_CYCLES; i++) begin
        r.motor = 1'b1; r.pulse = 1'b0; r.left = cv; exp_q.push_back(r);
      end
    for (int k = 0; k < int'(cv); k++) begin
      for (int i = 0; i < PULSE_CYCLES; i++) begin
        r.motor = 1'b0; r.pulse = 1'b1; r.left = 3'(int'(cv) - k); exp_q.push_back(r);
      end
      for (int i = 0; i < GAP_CYCLES; i++) begin
        r.motor = 1'b0; r.pulse = 1'b0; r.left = 3'(int'(cv) - k - 1); exp_q.push_back(r);
      end
    end
    r.motor = 1'b0; r.pulse = 1'b0; r.left = 3'd0; r.done = 1'b1;
    exp_q.push_back(r);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovr  = 1'b0;
    last_sel = 3'd0;
    cur_busy = 1'b0;
  endtask

  task automatic step(input logic dv, input logic [2:0] pv, input logic [2:0] cv);
    out_t e;
    d = dv; p = pv; c = cv;
    if (dv && !cur_busy) push_vend(pv, cv);
    if (dv && cur_busy) exp_ovr = 1'b1;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e = '0;
      e.sel = last_sel;
    end
    e.ovr = exp_ovr;
    last_act = sample();
    check_out("cycle", last_act, e);
    cur_busy = e.busy;
    d = 1'b0;
  endtask

  // Starts a vend and runs until done (bounded); optional second strobe at cycle inj.
  task automatic run_vend(input logic [2:0] pv, input logic [2:0] cv, input int inj,
                          output int mc, output int pc, output int da);
    logic prev_pulse;
    mc = 0; pc = 0; da = -1; prev_pulse = 1'b0;
    for (int k = 1; k <= 80 && da < 0; k++) begin
      if (k == 1) step(1'b1, pv, cv);
      else step(k == inj, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if (last_act.motor) mc++;
      if (last_act.pulse && !prev_pulse) pc++;
      prev_pulse = last_act.pulse;
      if (last_act.done) da = k;
    end
  endtask

  vec_t tbl[7];
  int   mc, pc, da;

  initial begin
    tbl[0] = '{p: 3'd3, c: 3'd0, motor: 8, pulses: 0, done_at: 9};
    tbl[1] = '{p: 3'd5, c: 3'd2, motor: 8, pulses: 2, done_at: 17};
    tbl[2] = '{p: 3'd0, c: 3'd1, motor: 0, pulses: 1, done_at: 5};
    tbl[3] = '{p: 3'd0, c: 3'd0, motor: 0, pulses: 0, done_at: 1};
    tbl[4] = '{p: 3'd7, c: 3'd7, motor: 8, pulses: 7, done_at: 37};
    tbl[5] = '{p: 3'd1, c: 3'd3, motor: 8, pulses: 3, done_at: 21};
    tbl[6] = '{p: 3'd0, c: 3'd7, motor: 0, pulses: 7, done_at: 29};

    model_reset();
    last_act = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_outputs", sample(), '0);
    check_int("reset_state", int'(fsm_state), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vend(tbl[i].p, tbl[i].c, 0, mc, pc, da);
      check_int("motor_cycles", mc, tbl[i].motor);
      check_int("pulse_count", pc, tbl[i].pulses);
      check_int("done_cycle", da, tbl[i].done_at);
      step(1'b0, 3'd0, 3'd0);
      check_int("busy_after_done", int'(busy), 0);
    end

    // Second strobe during the motor phase must only raise ovr.
    run_vend(3'd2, 3'd7, 4, mc, pc, da);
    check_int("ovr_pulse_count", pc, 7);
    check_int("ovr_done_cycle", da, 37);
    step(1'b0, 3'd5, 3'd3);
    check_int("ovr_sel_held", int'(motor_sel), 2);
    check_int("ovr_sticky", int'(ovr), 1);

    // Reset in the gap after the third coin aborts the vend.
    step(1'b1, 3'd0, 3'd5);
    pc = (last_act.pulse) ? 1 : 0;
    for (int k = 2; k <= 11; k++) begin
      logic prev;
      prev = last_act.pulse;
      step(1'b0, 3'd0, 3'd0);
      if (last_act.pulse && !prev) pc++;
    end
    check_int("abort_pulses_before", pc, 3);
    check_int("abort_in_gap", int'(fsm_state), 3);
    rst = 1'b1;
    d = 1'b1;
    @(posedge clk);
    #1;
    check_out("abort_outputs", sample(), '0);
    check_int("abort_state", int'(fsm_state), 0);
    rst = 1'b0;
    d = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 3'd4, 3'd4);
    run_vend(3'd6, 3'd1, 0, mc, pc, da);
    check_int("post_abort_done", da, 13);
    check_int("post_abort_pulses", pc, 1);

    // Random vends with random strobes and input noise while busy.
    for (int v = 0; v < 40; v++) begin
      step(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      for (int k = 0; k < 100 && cur_busy; k++)
        step($urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      check_int("rand_vend_finished", int'(cur_busy), 0);
      repeat ($urandom_range(0, 2)) step(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
